// File: rtl/pool_engine.sv
`default_nettype none
// =============================================================================
// pool_engine : streaming 2x2/stride-2 max/average pooling over LANES channels.
// Average datapath built only when POOL_AVG_MODE_EN is defined.   Rev 1.0
// =============================================================================
module pool_engine #(
  parameter int LANES    = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_FLEN = 64,
  parameter int FLEN_W   = 7,
  parameter int CH_W     = 9
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [LANES*DATA_W-1:0] S_AXIS_TDATA,
  input  logic                    S_AXIS_TVALID,
  output logic                    S_AXIS_TREADY,
  input  logic                    S_AXIS_TLAST,
  input  logic                    S_AXIS_TUSER,
  input  logic [LANES-1:0]        S_AXIS_TKEEP,
  output logic [LANES*DATA_W-1:0] M_AXIS_TDATA,
  output logic                    M_AXIS_TVALID,
  input  logic                    M_AXIS_TREADY,
  output logic                    M_AXIS_TLAST,
  output logic                    M_AXIS_TUSER,
  output logic [LANES-1:0]        M_AXIS_TKEEP,
  input  logic                    pool_start,
  output logic                    pool_done,
  output logic                    pool_err,
  input  logic [FLEN_W-1:0]       Flen,
  input  logic [CH_W-1:0]         num_INCH,
  input  logic                    avg_mode,
  output logic [31:0]             clk_counter
);

`ifdef POOL_AVG_MODE_EN
  localparam int PW = DATA_W + 1;
`else
  localparam int PW = DATA_W;
`endif
  localparam int DEPTH = MAX_FLEN / 2;
  localparam int BA_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_start_d, r_err;
  logic [FLEN_W-1:0]       r_flen, r_col, r_row;
  logic [CH_W-1:0]         r_groups, r_grp;
  logic                    r_m_valid, r_m_last, r_m_user;
  logic [LANES*DATA_W-1:0] r_m_data, r_hold, w_result;
  logic [31:0]             r_cyc;
  logic [LANES*PW-1:0]     r_lbuf [DEPTH];
  logic [LANES*PW-1:0]     w_pair, w_buf_rd;
  logic [BA_W-1:0]         w_bidx;
  logic                    w_start_edge, w_cfg_ok, w_accept, w_win_done;
  logic                    w_col_end, w_row_end, w_grp_end, w_last_in;

`ifdef POOL_AVG_MODE_EN
  logic r_avg;
  logic w_unused;
  assign w_unused = &{1'b0, S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TKEEP};
`else
  logic w_unused;
  assign w_unused = &{1'b0, S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TKEEP, avg_mode};
`endif

  assign w_start_edge = pool_start && !r_start_d;
  assign w_cfg_ok     = !Flen[0] && (Flen >= FLEN_W'(2)) && (Flen <= FLEN_W'(MAX_FLEN)) &&
                        (num_INCH != '0) && ((num_INCH % CH_W'(LANES)) == '0);
  assign w_accept     = S_AXIS_TREADY && S_AXIS_TVALID;
  assign w_col_end    = (r_col == r_flen - FLEN_W'(1));
  assign w_row_end    = (r_row == r_flen - FLEN_W'(1));
  assign w_grp_end    = (r_grp == r_groups - CH_W'(1));
  assign w_last_in    = w_accept && w_col_end && w_row_end && w_grp_end;
  assign w_win_done   = w_accept && r_col[0] && r_row[0];
  assign w_bidx       = BA_W'(r_col >> 1);
  assign w_buf_rd     = r_lbuf[w_bidx];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [DATA_W-1:0] w_px, w_hd;
    logic signed [PW-1:0]     w_px_e, w_hd_e, w_bf, w_mx_pr, w_pr, w_mx_res;
    assign w_px     = S_AXIS_TDATA[l*DATA_W +: DATA_W];
    assign w_hd     = r_hold[l*DATA_W +: DATA_W];
    assign w_px_e   = PW'(w_px);
    assign w_hd_e   = PW'(w_hd);
    assign w_bf     = w_buf_rd[l*PW +: PW];
    assign w_mx_pr  = (w_hd_e > w_px_e) ? w_hd_e : w_px_e;
    assign w_mx_res = (w_pr > w_bf) ? w_pr : w_bf;
`ifdef POOL_AVG_MODE_EN
    // Pair sums keep one guard bit; the 4-way sum needs a second before the floor shift.
    logic signed [PW-1:0] w_sum_pr;
    logic signed [PW:0]   w_sum4;
    assign w_sum_pr = w_hd_e + w_px_e;
    assign w_pr     = r_avg ? w_sum_pr : w_mx_pr;
    assign w_sum4   = (PW+1)'(w_pr) + (PW+1)'(w_bf);
    assign w_result[l*DATA_W +: DATA_W] = r_avg ? DATA_W'(w_sum4 >>> 2) : DATA_W'(w_mx_res);
`else
    assign w_pr     = w_mx_pr;
    assign w_result[l*DATA_W +: DATA_W] = DATA_W'(w_mx_res);
`endif
    assign w_pair[l*PW +: PW] = w_pr;
  end

  always_comb begin
    w_state_nxt   = r_state;
    S_AXIS_TREADY = 1'b0;
    pool_done     = 1'b0;
    case (r_state)
      S_IDLE:  if (w_start_edge) w_state_nxt = w_cfg_ok ? S_RUN : S_DONE;
      S_RUN: begin
        S_AXIS_TREADY = !r_m_valid || M_AXIS_TREADY;
        if (w_last_in) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: if (r_m_valid && M_AXIS_TREADY) w_state_nxt = S_DONE;
      S_DONE: begin
        pool_done = 1'b1;
        if (!pool_start) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_start_d <= 1'b0;
      r_err     <= 1'b0;
      r_flen    <= '0;
      r_groups  <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_grp     <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_user  <= 1'b0;
      r_m_data  <= '0;
      r_cyc     <= '0;
`ifdef POOL_AVG_MODE_EN
      r_avg     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_start_d <= pool_start;
      if (r_state == S_IDLE && w_start_edge) begin
        r_flen   <= Flen;
        r_groups <= num_INCH / CH_W'(LANES);
        r_err    <= !w_cfg_ok;
        r_cyc    <= '0;
        r_col    <= '0;
        r_row    <= '0;
        r_grp    <= '0;
`ifdef POOL_AVG_MODE_EN
        r_avg    <= avg_mode;
`endif
      end else if (r_state == S_DONE && !pool_start) begin
        r_err <= 1'b0;
      end
      if (r_state == S_RUN || r_state == S_FLUSH) r_cyc <= r_cyc + 32'd1;
      if (w_accept) begin
        if (w_col_end) begin
          r_col <= '0;
          if (w_row_end) begin
            r_row <= '0;
            r_grp <= w_grp_end ? '0 : r_grp + CH_W'(1);
          end else begin
            r_row <= r_row + FLEN_W'(1);
          end
        end else begin
          r_col <= r_col + FLEN_W'(1);
        end
      end
      // Loading a new window result and draining the old one may share a cycle.
      if (w_win_done) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_result;
        r_m_last  <= w_last_in;
        r_m_user  <= (r_row == FLEN_W'(1)) && (r_col == FLEN_W'(1)) && (r_grp == '0);
      end else if (M_AXIS_TREADY) begin
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
        r_m_user  <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_accept && !r_col[0]) r_hold <= S_AXIS_TDATA;
    if (w_accept && r_col[0] && !r_row[0]) r_lbuf[w_bidx] <= w_pair;
  end

  assign M_AXIS_TDATA  = r_m_data;
  assign M_AXIS_TVALID = r_m_valid;
  assign M_AXIS_TLAST  = r_m_last;
  assign M_AXIS_TUSER  = r_m_user;
  assign M_AXIS_TKEEP  = '1;
  assign pool_err      = r_err;
  assign clk_counter   = r_cyc;

endmodule
`default_nettype wire

// File: tb/tb_pool_engine.sv
`default_nettype none
// =============================================================================
// tb_pool_engine : self-checking bench for pool_engine (window table, model-driven
// jobs with scoreboard, config errors, mid-job reset).   Rev 1.0
// =============================================================================
module tb_pool_engine;
  localparam int LANES = 4, DATA_W = 8, MAX_FLEN = 64, FLEN_W = 7, CH_W = 9;
  localparam int TW = LANES * DATA_W;
`ifdef POOL_AVG_MODE_EN
  localparam bit AVG_EN = 1'b1;
`else
  localparam bit AVG_EN = 1'b0;
`endif

  logic CLK = 1'b0, RESET;
  logic [TW-1:0] S_AXIS_TDATA, M_AXIS_TDATA;
  logic S_AXIS_TVALID, S_AXIS_TREADY, S_AXIS_TLAST, S_AXIS_TUSER;
  logic [LANES-1:0] S_AXIS_TKEEP, M_AXIS_TKEEP;
  logic M_AXIS_TVALID, M_AXIS_TREADY, M_AXIS_TLAST, M_AXIS_TUSER;
  logic pool_start, pool_done, pool_err, avg_mode;
  logic [FLEN_W-1:0] Flen;
  logic [CH_W-1:0] num_INCH;
  logic [31:0] clk_counter;

  always #5 CLK = ~CLK;

  pool_engine #(.LANES(LANES), .DATA_W(DATA_W), .MAX_FLEN(MAX_FLEN), .FLEN_W(FLEN_W), .CH_W(CH_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
    .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TUSER(S_AXIS_TUSER), .S_AXIS_TKEEP(S_AXIS_TKEEP),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TUSER(M_AXIS_TUSER), .M_AXIS_TKEEP(M_AXIS_TKEEP),
    .pool_start(pool_start), .pool_done(pool_done), .pool_err(pool_err),
    .Flen(Flen), .num_INCH(num_INCH), .avg_mode(avg_mode), .clk_counter(clk_counter)
  );

  typedef struct packed { logic user; logic last; logic [TW-1:0] data; } beat_t;
  typedef struct { int p[4]; bit avg; int e_max; int e_avg; } win_t;
  typedef struct { int f; int nch; bit avg; int pat; int rp; bit tog; } job_t;
  typedef struct { int f; int nch; } ecfg_t;

  beat_t         sb[$];
  logic [TW-1:0] inb[];
  int            win_p[4];
  int            n_tests = 0, n_fail = 0;
  int            ready_pct = 100;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int px(input int idx, input int l);
    return int'($signed(inb[idx][l*DATA_W +: DATA_W]));
  endfunction

  // Reference: output (g,wr,wc) from the four source pixels of that window.
  function automatic logic [TW-1:0] model(input int g, input int wr, input int wc, input int f, input bit avg);
    logic [TW-1:0] res;
    int v, s, m, idx;
    res = '0;
    for (int l = 0; l < LANES; l++) begin
      s = 0;
      m = -1000;
      for (int k = 0; k < 4; k++) begin
        idx = g*f*f + (2*wr + k/2)*f + 2*wc + (k%2);
        v = px(idx, l);
        s += v;
        if (v > m) m = v;
      end
      res[l*DATA_W +: DATA_W] = (avg && AVG_EN) ? DATA_W'(s >>> 2) : DATA_W'(m);
    end
    return res;
  endfunction

  initial begin
    M_AXIS_TREADY = 1'b0;
    forever begin
      @(posedge CLK);
      #1 M_AXIS_TREADY = (int'($urandom_range(0, 99)) < ready_pct);
    end
  end

  // Output monitor: pops the scoreboard on each handshake; checks stability while stalled.
  initial begin
    logic  stall_q;
    beat_t cur, prev_b, e;
    stall_q = 1'b0;
    prev_b  = '0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        stall_q = 1'b0;
      end else begin
        cur = '{user: M_AXIS_TUSER, last: M_AXIS_TLAST, data: M_AXIS_TDATA};
        if (stall_q && M_AXIS_TVALID) chk("hold_stable", cur, prev_b);
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_beat: got 0x%0h, expected no beat", cur);
          end else begin
            e = sb.pop_front();
            chk("out_beat", cur, e);
          end
        end
        stall_q = M_AXIS_TVALID && !M_AXIS_TREADY;
        prev_b  = cur;
      end
    end
  end

  task automatic run_job(input int f, input int nch, input bit avg, input int pat, input int rp,
                         input bit tog, input int abort_at, input bit use_exp, input logic [DATA_W-1:0] exp_v);
    int groups, nb, g, r, c, t, v;
    logic [31:0] cnt;
    beat_t e;
    groups = nch / LANES;
    nb = f * f * groups;
    inb = new[nb];
    for (int i = 0; i < nb; i++) begin
      g = i / (f*f); r = (i / f) % f; c = i % f;
      for (int l = 0; l < LANES; l++) begin
        v = (r*f + c)*(l + 1) - 3*l + 5*g;
        case (pat)
          0: inb[i][l*DATA_W +: DATA_W] = DATA_W'(v);
          1: inb[i][l*DATA_W +: DATA_W] = DATA_W'(-v);
          2: inb[i][l*DATA_W +: DATA_W] = DATA_W'($urandom);
          default: inb[i][l*DATA_W +: DATA_W] = DATA_W'(win_p[i % 4]);
        endcase
      end
    end
    ready_pct = rp;
    Flen = FLEN_W'(f); num_INCH = CH_W'(nch); avg_mode = avg;
    pool_start = 1'b0;
    @(posedge CLK); #1;
    pool_start = 1'b1;
    for (int i = 0; i < nb; i++) begin
      if (i == abort_at) begin
        S_AXIS_TVALID = 1'b0;
        return;
      end
      g = i / (f*f); r = (i / f) % f; c = i % f;
      if (tog && i == nb/2) begin
        S_AXIS_TVALID = 1'b0;
        pool_start = 1'b0;
        repeat (2) @(posedge CLK);
        #1 pool_start = 1'b1;
      end
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        e.user = (g == 0) && (r == 1) && (c == 1);
        e.last = (i == nb - 1);
        e.data = use_exp ? {LANES{exp_v}} : model(g, r/2, c/2, f, avg);
        sb.push_back(e);
      end
      S_AXIS_TDATA  = inb[i];
      S_AXIS_TVALID = 1'b1;
      t = 0;
      forever begin
        @(negedge CLK);
        if (S_AXIS_TREADY) break;
        t++;
        if (t > 2000) begin
          chk("tready_timeout", 0, 1);
          S_AXIS_TVALID = 1'b0;
          return;
        end
      end
      @(posedge CLK); #1;
    end
    S_AXIS_TVALID = 1'b0;
    t = 0;
    while (!pool_done && t < 5000) begin
      @(negedge CLK);
      t++;
    end
    chk("job_done", pool_done, 1);
    chk("job_err", pool_err, 0);
    chk("sb_empty", sb.size(), 0);
    chk("tvalid_idle", M_AXIS_TVALID, 0);
    chk("cnt_min", (clk_counter >= nb), 1);
    if (rp == 100 && !tog) chk("cnt_exact", clk_counter, nb + 1);
    cnt = clk_counter;
    @(negedge CLK);
    chk("cnt_hold", clk_counter, cnt);
    pool_start = 1'b0;
    repeat (2) @(negedge CLK);
    chk("done_clear", pool_done, 0);
  endtask

  task automatic err_cfg(input int f, input int nch);
    bit saw_ready;
    saw_ready = 1'b0;
    pool_start = 1'b0;
    @(posedge CLK); #1;
    Flen = FLEN_W'(f); num_INCH = CH_W'(nch); avg_mode = 1'b0;
    S_AXIS_TDATA = '1; S_AXIS_TVALID = 1'b1;
    pool_start = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      saw_ready |= S_AXIS_TREADY;
    end
    chk("err_flag", pool_err, 1);
    chk("err_done", pool_done, 1);
    chk("err_counter", clk_counter, 0);
    repeat (3) begin
      @(negedge CLK);
      saw_ready |= S_AXIS_TREADY;
    end
    chk("err_no_tready", saw_ready, 0);
    S_AXIS_TVALID = 1'b0;
    pool_start = 1'b0;
    repeat (2) @(negedge CLK);
    chk("err_clear", pool_err, 0);
    chk("err_done_clear", pool_done, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    win_t  wt[8];
    job_t  jt[6];
    ecfg_t et[7];
    int    ev;

    wt[0] = '{p: '{0, 1, 4, 5},         avg: 1'b0, e_max: 5,    e_avg: 2};
    wt[1] = '{p: '{-1, -2, -3, -4},     avg: 1'b1, e_max: -1,   e_avg: -3};
    wt[2] = '{p: '{1, 2, 3, 4},         avg: 1'b1, e_max: 4,    e_avg: 2};
    wt[3] = '{p: '{127, -128, 0, 5},    avg: 1'b0, e_max: 127,  e_avg: 1};
    wt[4] = '{p: '{-128, -128, -128, -128}, avg: 1'b1, e_max: -128, e_avg: -128};
    wt[5] = '{p: '{127, 127, 127, 127}, avg: 1'b1, e_max: 127,  e_avg: 127};
    wt[6] = '{p: '{-1, 0, 0, 0},        avg: 1'b1, e_max: 0,    e_avg: -1};
    wt[7] = '{p: '{3, -7, 2, -1},       avg: 1'b1, e_max: 3,    e_avg: -1};

    jt[0] = '{f: 4,  nch: 4,  avg: 1'b0, pat: 0, rp: 100, tog: 1'b0};
    jt[1] = '{f: 4,  nch: 4,  avg: 1'b0, pat: 1, rp: 100, tog: 1'b0};
    jt[2] = '{f: 8,  nch: 8,  avg: 1'b0, pat: 2, rp: 30,  tog: 1'b1};
    jt[3] = '{f: 4,  nch: 8,  avg: 1'b1, pat: 2, rp: 60,  tog: 1'b0};
    jt[4] = '{f: 64, nch: 4,  avg: 1'b0, pat: 2, rp: 100, tog: 1'b0};
    jt[5] = '{f: 2,  nch: 12, avg: 1'b1, pat: 2, rp: 50,  tog: 1'b0};

    et[0] = '{f: 5,   nch: 4};
    et[1] = '{f: 4,   nch: 6};
    et[2] = '{f: 0,   nch: 4};
    et[3] = '{f: 66,  nch: 4};
    et[4] = '{f: 4,   nch: 0};
    et[5] = '{f: 3,   nch: 8};
    et[6] = '{f: 127, nch: 4};

    RESET = 1'b1; pool_start = 1'b0; avg_mode = 1'b0; Flen = '0; num_INCH = '0;
    S_AXIS_TDATA = '0; S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0; S_AXIS_TUSER = 1'b0; S_AXIS_TKEEP = '1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_tvalid", M_AXIS_TVALID, 0);
    chk("rst_tdata", M_AXIS_TDATA, 0);
    chk("rst_flags", {M_AXIS_TUSER, M_AXIS_TLAST, pool_done, pool_err, S_AXIS_TREADY}, 0);
    chk("rst_tkeep", M_AXIS_TKEEP, {LANES{1'b1}});
    chk("rst_counter", clk_counter, 0);
    @(posedge CLK); #1 RESET = 1'b0;

    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) win_p[k] = wt[i].p[k];
      ev = (wt[i].avg && AVG_EN) ? wt[i].e_avg : wt[i].e_max;
      run_job(2, 4, wt[i].avg, 3, 100, 1'b0, -1, 1'b1, DATA_W'(ev));
    end

    for (int i = 0; i < 6; i++)
      run_job(jt[i].f, jt[i].nch, jt[i].avg, jt[i].pat, jt[i].rp, jt[i].tog, -1, 1'b0, '0);

    for (int i = 0; i < 7; i++) err_cfg(et[i].f, et[i].nch);

    // Abort a job after 7 accepted inputs, then rerun from scratch.
    run_job(4, 4, 1'b0, 0, 100, 1'b0, 7, 1'b0, '0);
    RESET = 1'b1;
    pool_start = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("midrst_tvalid", M_AXIS_TVALID, 0);
    chk("midrst_tdata", M_AXIS_TDATA, 0);
    chk("midrst_flags", {M_AXIS_TUSER, M_AXIS_TLAST, pool_done, pool_err, S_AXIS_TREADY}, 0);
    chk("midrst_counter", clk_counter, 0);
    chk("midrst_tkeep", M_AXIS_TKEEP, {LANES{1'b1}});
    sb.delete();
    @(posedge CLK); #1 RESET = 1'b0;
    run_job(4, 4, 1'b0, 2, 100, 1'b0, -1, 1'b0, '0);

    repeat (4) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
